// File: rtl/gip_wbq_pkg.sv
// Shared widths and the queued register-write entry for the write-back queue.
package gip_wbq_pkg;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 16;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wbq_entry_t;

  function automatic logic [RF_NUM_REGS-1:0] addr_onehot(input logic [RF_ADDR_W-1:0] a);
    addr_onehot    = '0;
    addr_onehot[a] = 1'b1;
  endfunction
endpackage

// File: rtl/gip_wbq_fifo.sv
// In-order circular store: two pushes (A then B) and one pop per cycle; pops whenever non-empty.
// Presents its contents oldest-first so the consumer never deals with pointer wrap.
module gip_wbq_fifo
  import gip_wbq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_a,
  input  wbq_entry_t                     entry_a,
  input  logic                           push_b,
  input  wbq_entry_t                     entry_b,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output wbq_entry_t [DEPTH-1:0]         ordered
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wbq_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   pop;

  assign pop   = (count_q != '0);
  assign count = count_q;

  always_comb begin
    mem_d = mem_q;
    if (push_a) mem_d[tail_q] = entry_a;
    // B lands behind A in the same cycle so its write to a shared register wins.
    if (push_b) mem_d[tail_q + PTR_W'(push_a)] = entry_b;
    tail_d  = tail_q + PTR_W'(push_a) + PTR_W'(push_b);
    head_d  = pop ? head_q + PTR_W'(1) : head_q;
    count_d = count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) ordered[k] = mem_q[head_q + PTR_W'(k)];
  end
endmodule

// File: rtl/gip_rf_wb_queue.sv
// Write-back queue in front of the 16x32 register file: ALU (A) and load (B) writes drain one per cycle, 1-cycle latency when empty.
// Readies come from occupancy only (B needs two free slots); WBQ_BYPASS_EN adds a newest-match data bypass.
module gip_rf_wb_queue
  import gip_wbq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        wbq_clock,
  input  logic        wbq_reset,
  input  logic        a_wr_valid,
  input  logic [3:0]  a_wr_addr,
  input  logic [31:0] a_wr_data,
  output logic        a_wr_ready,
  input  logic        b_wr_valid,
  input  logic [3:0]  b_wr_addr,
  input  logic [31:0] b_wr_data,
  output logic        b_wr_ready,
  output logic        rf_wr_enable,
  output logic [3:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
`ifdef WBQ_BYPASS_EN
  input  logic [3:0]  byp_rd_addr,
  output logic        byp_hit,
  output logic [31:0] byp_data,
`endif
  output logic [15:0] wbq_pending
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0]       count;
  wbq_entry_t [DEPTH-1:0] ordered;
  logic [CNT_W:0]         space;
  wbq_entry_t             entry_a, entry_b;

  // The head slot frees at this edge, so it counts as space.
  assign space      = (CNT_W+1)'(DEPTH) - {1'b0, count} + {{CNT_W{1'b0}}, (count != '0)};
  assign a_wr_ready = (space >= (CNT_W+1)'(1));
  assign b_wr_ready = (space >= (CNT_W+1)'(2));

  assign entry_a = {a_wr_addr, a_wr_data};
  assign entry_b = {b_wr_addr, b_wr_data};

  gip_wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (wbq_clock),
    .rst_n   (wbq_reset),
    .push_a  (a_wr_valid & a_wr_ready),
    .entry_a (entry_a),
    .push_b  (b_wr_valid & b_wr_ready),
    .entry_b (entry_b),
    .count   (count),
    .ordered (ordered)
  );

  assign rf_wr_enable = (count != '0);
  assign rf_wr_addr   = rf_wr_enable ? ordered[0].addr : '0;
  assign rf_wr_data   = rf_wr_enable ? ordered[0].data : '0;

  always_comb begin
    wbq_pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count) wbq_pending = wbq_pending | addr_onehot(ordered[k].addr);
    end
  end

`ifdef WBQ_BYPASS_EN
  // Scan oldest to newest so the last match (closest to tail) wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count) && (ordered[k].addr == byp_rd_addr)) begin
        byp_hit  = 1'b1;
        byp_data = ordered[k].data;
      end
    end
  end
`endif
endmodule

// File: tb/tb_gip_rf_wb_queue.sv
// Randomized and directed bench for gip_rf_wb_queue against a queue-based model.
module tb_gip_rf_wb_queue;
  localparam int DEPTH = 4;

  logic        wbq_clock = 1'b0;
  logic        wbq_reset;
  logic        a_wr_valid, b_wr_valid;
  logic [3:0]  a_wr_addr, b_wr_addr;
  logic [31:0] a_wr_data, b_wr_data;
  logic        a_wr_ready, b_wr_ready;
  logic        rf_wr_enable;
  logic [3:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [15:0] wbq_pending;
`ifdef WBQ_BYPASS_EN
  logic [3:0]  byp_rd_addr;
  logic        byp_hit;
  logic [31:0] byp_data;
  logic        byp_hold;
`endif

  logic [35:0] mq[$];
  int total = 0;
  int bad   = 0;

  always #5 wbq_clock = ~wbq_clock;

  gip_rf_wb_queue #(.DEPTH(DEPTH)) dut (
    .wbq_clock    (wbq_clock),
    .wbq_reset    (wbq_reset),
    .a_wr_valid   (a_wr_valid),
    .a_wr_addr    (a_wr_addr),
    .a_wr_data    (a_wr_data),
    .a_wr_ready   (a_wr_ready),
    .b_wr_valid   (b_wr_valid),
    .b_wr_addr    (b_wr_addr),
    .b_wr_data    (b_wr_data),
    .b_wr_ready   (b_wr_ready),
    .rf_wr_enable (rf_wr_enable),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
`ifdef WBQ_BYPASS_EN
    .byp_rd_addr  (byp_rd_addr),
    .byp_hit      (byp_hit),
    .byp_data     (byp_data),
`endif
    .wbq_pending  (wbq_pending)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int model_space();
    int n;
    n = mq.size();
    return DEPTH - n + ((n != 0) ? 1 : 0);
  endfunction

  // Compare every DUT output with what the queued writes imply.
  task automatic model_check();
    int          n;
    logic [15:0] pend;
    n    = mq.size();
    pend = '0;
    foreach (mq[i]) pend[mq[i][35:32]] = 1'b1;
    chk("a_ready", 32'(a_wr_ready), 32'(model_space() >= 1));
    chk("b_ready", 32'(b_wr_ready), 32'(model_space() >= 2));
    chk("rf_en",   32'(rf_wr_enable), 32'(n != 0));
    chk("rf_addr", 32'(rf_wr_addr), (n != 0) ? 32'(mq[0][35:32]) : 32'd0);
    chk("rf_data", rf_wr_data, (n != 0) ? mq[0][31:0] : 32'd0);
    chk("pending", 32'(wbq_pending), 32'(pend));
`ifdef WBQ_BYPASS_EN
    begin
      logic        hit;
      logic [31:0] dat;
      hit = 1'b0;
      dat = '0;
      foreach (mq[i]) if (mq[i][35:32] == byp_rd_addr) begin hit = 1'b1; dat = mq[i][31:0]; end
      chk("byp_hit",  32'(byp_hit), 32'(hit));
      chk("byp_data", byp_data, dat);
    end
`endif
  endtask

  // Called at a falling edge: check, drive, advance model, move to the next falling edge.
  task automatic step(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [3:0] ba, input logic [31:0] bd);
    logic acc_a, acc_b;
    model_check();
    acc_a = av && (model_space() >= 1);
    acc_b = bv && (model_space() >= 2);
    a_wr_valid = av; a_wr_addr = aa; a_wr_data = ad;
    b_wr_valid = bv; b_wr_addr = ba; b_wr_data = bd;
`ifdef WBQ_BYPASS_EN
    if (!byp_hold) byp_rd_addr = 4'($urandom_range(0, 15));
`endif
    if (mq.size() != 0) void'(mq.pop_front());
    if (acc_a) mq.push_back({aa, ad});
    if (acc_b) mq.push_back({ba, bd});
    @(posedge wbq_clock);
    @(negedge wbq_clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    wbq_reset  = 1'b0;
    a_wr_valid = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    b_wr_valid = 1'b0; b_wr_addr = '0; b_wr_data = '0;
`ifdef WBQ_BYPASS_EN
    byp_rd_addr = '0;
    byp_hold    = 1'b0;
`endif
    #1;
    chk("rst_rf_en",   32'(rf_wr_enable), 32'd0);
    chk("rst_rf_addr", 32'(rf_wr_addr), 32'd0);
    chk("rst_rf_data", rf_wr_data, 32'd0);
    chk("rst_pending", 32'(wbq_pending), 32'h0000);
    @(posedge wbq_clock);
    @(negedge wbq_clock);
    wbq_reset = 1'b1;
    @(negedge wbq_clock);
    chk("post_rst_a_ready", 32'(a_wr_ready), 32'd1);
    chk("post_rst_b_ready", 32'(b_wr_ready), 32'd1);

    // Single write
    step(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
    chk("single_c1_en",   32'(rf_wr_enable), 32'd1);
    chk("single_c1_addr", 32'(rf_wr_addr), 32'd3);
    chk("single_c1_data", rf_wr_data, 32'hDEADBEEF);
    chk("single_c1_pend", 32'(wbq_pending), 32'h0008);
    idle(1);
    chk("single_c2_en",   32'(rf_wr_enable), 32'd0);
    chk("single_c2_pend", 32'(wbq_pending), 32'h0000);

    // Same register from both ports: A lands first, B last
    step(1'b1, 4'd5, 32'h1, 1'b1, 4'd5, 32'h2);
    chk("same_c1_addr", 32'(rf_wr_addr), 32'd5);
    chk("same_c1_data", rf_wr_data, 32'h1);
    chk("same_c1_pend", 32'(wbq_pending[5]), 32'd1);
    idle(1);
    chk("same_c2_data", rf_wr_data, 32'h2);
    chk("same_c2_pend", 32'(wbq_pending[5]), 32'd1);
    idle(1);
    chk("same_c3_pend", 32'(wbq_pending[5]), 32'd0);
    chk("same_c3_en",   32'(rf_wr_enable), 32'd0);

    // Saturation
    for (int c = 0; c < 7; c++) begin
      chk("sat_a_ready", 32'(a_wr_ready), 32'd1);
      chk("sat_b_ready", 32'(b_wr_ready), (c >= 3) ? 32'd0 : 32'd1);
      if (c >= 1) chk("sat_rf_en", 32'(rf_wr_enable), 32'd1);
      step(1'b1, 4'(c), 32'hA000 + 32'(c), 1'b1, 4'(c + 8), 32'hB000 + 32'(c));
    end
    idle(DEPTH + 1);

    // Reset with entries in flight
    step(1'b1, 4'd1, 32'h111, 1'b1, 4'd2, 32'h222);
    step(1'b1, 4'd3, 32'h333, 1'b1, 4'd4, 32'h444);
    model_check();
    chk("mid_pre_en", 32'(rf_wr_enable), 32'd1);
    wbq_reset = 1'b0;
    #1;
    chk("mid_rst_en",   32'(rf_wr_enable), 32'd0);
    chk("mid_rst_addr", 32'(rf_wr_addr), 32'd0);
    chk("mid_rst_data", rf_wr_data, 32'd0);
    chk("mid_rst_pend", 32'(wbq_pending), 32'h0000);
    mq.delete();
    a_wr_valid = 1'b0;
    b_wr_valid = 1'b0;
    @(posedge wbq_clock);
    @(negedge wbq_clock);
    wbq_reset = 1'b1;
    @(negedge wbq_clock);
    chk("mid_post_a_ready", 32'(a_wr_ready), 32'd1);
    chk("mid_post_b_ready", 32'(b_wr_ready), 32'd1);
    idle(4);

`ifdef WBQ_BYPASS_EN
    byp_hold = 1'b1;
    step(1'b1, 4'd7, 32'h11, 1'b1, 4'd7, 32'h22);
    byp_rd_addr = 4'd7;
    #1;
    chk("byp_c1_hit",  32'(byp_hit), 32'd1);
    chk("byp_c1_data", byp_data, 32'h22);
    idle(2);
    chk("byp_c3_hit",  32'(byp_hit), 32'd0);
    byp_hold = 1'b0;
`endif

    // Randomized traffic, biased toward a few registers to force collisions
    for (int i = 0; i < 600; i++) begin
      logic av, bv;
      av = ($urandom_range(0, 99) < 65);
      bv = ($urandom_range(0, 99) < 55);
      step(av, 4'($urandom_range(0, 5)), $urandom, bv, 4'($urandom_range(0, 15)), $urandom);
    end
    idle(DEPTH + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
